// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the RV64 core front end:
//                address width, reset PC, NOP encoding, fetch FSM states and
//                the major opcodes used by the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          XLEN             = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_ARITH  = 7'b0110011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,    // ready to issue a request
        ST_WAIT  = 2'd1,    // one request outstanding, response kept
        ST_DROP  = 2'd2     // one request outstanding, response discarded
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Instruction-memory request/response bundle. The fetch stage
//                is the master, instruction memory is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_skid_buf
//  Description : One-entry {instr, pc} buffer that catches a fetch response
//                arriving while decode is stalled. hold marks occupancy.
//                Priority: flush > load > drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_skid_buf
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            load,
    input  wire logic            drain,
    input  wire logic            flush,
    input  wire logic [31:0]     in_instr,
    input  wire logic [XLEN-1:0] in_pc,
    output logic                 hold,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_pc
);

    logic            hold_q,  hold_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    // Next-state: a redirect empties the buffer even if a load is requested.
    always_comb begin
        hold_d  = hold_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            hold_d = 1'b0;
        end else if (load) begin
            hold_d  = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end else if (drain) begin
            hold_d = 1'b0;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign hold      = hold_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : RV64 instruction fetch stage. Holds the PC, issues one
//                outstanding 32-bit fetch at a time, fills the registered
//                IF/ID slot, absorbs decode stalls with a one-entry skid
//                buffer and cancels in-flight responses on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC_DEFAULT)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    instr_fetch_if.master        imem,
    input  wire logic            stall,
    input  wire logic            branch_taken,
    input  wire logic [XLEN-1:0] branch_target,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    output logic [XLEN-1:0]      if_pc,
    output logic [6:0]           if_opcode
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q,    if_pc_d;

    logic            skid_hold, skid_load, skid_drain, skid_flush;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            slot_free;
    logic            req_fire;
    logic            rsp_pending;

    // The slot can take new data if it is empty or decode is draining it now.
    assign slot_free = !if_valid_q || !stall;

    assign imem.imem_req_valid = !rst && (state_q == ST_FETCH) && !skid_hold;
    assign imem.imem_req_addr  = pc_q;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    // A response is still owed after this cycle if one was accepted now, or
    // one is outstanding and does not arrive this cycle. Only then can DROP
    // be left by a later beat; otherwise the beat is discarded in this cycle.
    assign rsp_pending = (state_q == ST_FETCH && req_fire) ||
                         ((state_q == ST_WAIT || state_q == ST_DROP) && !imem.imem_rsp_valid);

    if_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .drain     (skid_drain),
        .flush     (skid_flush),
        .in_instr  (imem.imem_rsp_data),
        .in_pc     (pc_q),
        .hold      (skid_hold),
        .out_instr (skid_instr),
        .out_pc    (skid_pc)
    );

    // Next-state, PC and IF/ID slot update; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (branch_taken) begin
            pc_d       = {branch_target[XLEN-1:2], 2'b00};
            if_valid_d = 1'b0;
            skid_flush = 1'b1;
            state_d    = rsp_pending ? ST_DROP : ST_FETCH;
        end else begin
            if (if_valid_q && !stall) begin
                if_valid_d = 1'b0;
            end
            if (skid_hold && slot_free) begin
                if_valid_d = 1'b1;
                if_instr_d = skid_instr;
                if_pc_d    = skid_pc;
                skid_drain = 1'b1;
            end
            case (state_q)
                ST_FETCH: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_FETCH;
                        if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_instr_d = imem.imem_rsp_data;
                            if_pc_d    = pc_q;
                        end else begin
                            skid_load = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem.imem_rsp_valid) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State, PC and IF/ID slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_opcode = if_instr_q[6:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Bench for instr_fetch. A memory model answers fetches with
//                random ready/latency; the expected decode stream is the
//                sequence of consecutive PCs since the last reset/redirect,
//                each paired with the memory word at that PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [6:0]  if_opcode;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode;       // 0 random, 1 always ready, 2 never ready
    int lat_min;
    int lat_max;

    logic [63:0] exp_q[$];  // expected PCs presented to decode, in order

    instr_fetch_if #(.XLEN(64)) imem ();

    instr_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_opcode     (if_opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        logic [6:0]  opc;
        if (a == 64'h3000) return 32'h0000_0033;   // add
        if (a == 64'h3004) return 32'h0000_3083;   // ld
        h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5BD1_E995;
        case (a[4:2])
            3'd0:    opc = 7'b0110011;
            3'd1:    opc = 7'b0000011;
            3'd2:    opc = 7'b0100011;
            3'd3:    opc = 7'b1100011;
            default: opc = h[6:0];
        endcase
        return {h[31:7], opc};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_valid"}, {63'd0, imem.imem_req_valid}, 64'd0);
        chk({tag, "_if_valid"},  {63'd0, if_valid}, 64'd0);
        chk({tag, "_if_instr"},  {32'd0, if_instr}, 64'h13);
        chk({tag, "_if_pc"},     if_pc, 64'd0);
        chk({tag, "_if_opcode"}, {57'd0, if_opcode}, 64'h13);
    endtask

    task automatic redirect(input logic [63:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        exp_q.delete();
        exp_q.push_back({tgt[63:2], 2'b00});
    endtask

    // Instruction memory: accepts when ready, answers after lat_min..lat_max cycles.
    initial begin : mem_model
        logic        acc;
        logic [63:0] acc_addr;
        logic        pend;
        int          wt;
        logic [63:0] paddr;
        pend = 1'b0;
        wt = 0;
        paddr = '0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = !rst && imem.imem_req_valid && imem.imem_req_ready;
            acc_addr = imem.imem_req_addr;
            if (acc) begin
                chk("one_outstanding", {63'd0, pend || imem.imem_rsp_valid}, 64'd0);
                chk("addr_aligned", {62'd0, acc_addr[1:0]}, 64'd0);
            end
            @(posedge clk);
            #2;
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend  = 1'b1;
                    paddr = acc_addr;
                    wt    = int'($urandom_range(lat_max, lat_min)) - 1;
                end
                if (pend) begin
                    if (wt == 0) begin
                        imem.imem_rsp_valid = 1'b1;
                        imem.imem_rsp_data  = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        wt--;
                    end
                end
            end
            case (rdy_mode)
                1:       imem.imem_req_ready = 1'b1;
                2:       imem.imem_req_ready = 1'b0;
                default: imem.imem_req_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every decode consumption.
    initial begin : monitor
        logic [63:0] e;
        logic [31:0] w;
        logic        prev_wait;
        logic [63:0] prev_addr;
        int          idle;
        prev_wait = 1'b0;
        prev_addr = '0;
        idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wait = 1'b0;
                idle = 0;
            end else begin
                if (prev_wait) begin
                    chk("req_stable_valid", {63'd0, imem.imem_req_valid}, 64'd1);
                    chk("req_stable_addr", imem.imem_req_addr, prev_addr);
                end
                prev_wait = imem.imem_req_valid && !imem.imem_req_ready && !branch_taken;
                prev_addr = imem.imem_req_addr;
                if (if_valid && !stall && !branch_taken) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_empty: got pc %h expected no delivery", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        chk("sb_pc", if_pc, e);
                        chk("sb_instr", {32'd0, if_instr}, {32'd0, w});
                        chk("sb_opcode", {57'd0, if_opcode}, {57'd0, w[6:0]});
                        if (exp_q.size() == 0) exp_q.push_back(e + 64'd4);
                    end
                end else begin
                    idle++;
                    if (idle == 400) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL watchdog: got %0d idle cycles expected progress", idle);
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin : driver
        logic [63:0] tgt;
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        rdy_mode = 1;
        lat_min = 1;
        lat_max = 1;
        exp_q.delete();
        exp_q.push_back(RST_PC);

        repeat (2) cyc();
        check_reset("rst0");
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("first_req_addr", imem.imem_req_addr, RST_PC);
        cyc();
        // Back-to-back fetch: a new instruction every second cycle.
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("thru_valid", {63'd0, if_valid}, (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0) chk("thru_pc", if_pc, RST_PC + 64'(4 * (i / 2)));
        end

        // Stall: slot holds 0x100C, 0x1010 lands in the skid, no new request.
        stall = 1'b1;
        repeat (8) cyc();
        chk("stall_if_valid", {63'd0, if_valid}, 64'd1);
        chk("stall_if_pc", if_pc, 64'h100C);
        chk("stall_no_req", {63'd0, imem.imem_req_valid}, 64'd0);
        stall = 1'b0;
        cyc();
        chk("drain_if_pc", if_pc, 64'h1010);
        chk("drain_if_valid", {63'd0, if_valid}, 64'd1);
        chk("resume_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("resume_req_addr", imem.imem_req_addr, 64'h1014);

        // Redirect while waiting on a 3-cycle response.
        lat_min = 3;
        lat_max = 3;
        cyc();
        redirect(64'h2003);
        cyc();
        branch_taken = 1'b0;
        chk("drop_if_valid", {63'd0, if_valid}, 64'd0);
        chk("drop_no_req0", {63'd0, imem.imem_req_valid}, 64'd0);
        cyc();
        chk("drop_no_req1", {63'd0, imem.imem_req_valid}, 64'd0);
        cyc();
        chk("redir_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("redir_req_addr", imem.imem_req_addr, 64'h2000);

        // Redirect in the same cycle the request is accepted.
        redirect(64'h3000);
        cyc();
        branch_taken = 1'b0;
        chk("acc_drop_no_req", {63'd0, imem.imem_req_valid}, 64'd0);
        repeat (3) cyc();
        chk("acc_redir_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("acc_redir_addr", imem.imem_req_addr, 64'h3000);
        lat_min = 1;
        lat_max = 1;
        repeat (2) cyc();
        chk("add_opcode", {57'd0, if_opcode}, 64'h33);
        chk("add_instr", {32'd0, if_instr}, 64'h33);
        repeat (2) cyc();
        chk("ld_opcode", {57'd0, if_opcode}, 64'h03);
        chk("ld_pc", if_pc, 64'h3004);

        // Memory not ready: request and address held.
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("nordy_valid", {63'd0, imem.imem_req_valid}, 64'd1);
            chk("nordy_addr", imem.imem_req_addr, 64'h3008);
        end
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        #1;
        check_reset("rst1");
        repeat (2) cyc();
        rdy_mode = 0;
        lat_min = 1;
        lat_max = 4;
        rst = 1'b0;

        // Randomized traffic with stalls, redirects (some near PC wrap) and a reset.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            stall = ($urandom_range(9, 0) < 3);
            if (c == 1500) begin
                rst = 1'b1;
                branch_taken = 1'b0;
                exp_q.delete();
                exp_q.push_back(RST_PC);
                repeat (2) cyc();
                rst = 1'b0;
            end else if (branch_taken) begin
                branch_taken = 1'b0;
            end else if ($urandom_range(39, 0) == 0) begin
                if ($urandom_range(3, 0) == 0)
                    tgt = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31, 0));
                else
                    tgt = {$urandom, $urandom};
                redirect(tgt);
            end
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        repeat (10) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : timeout
        #1_000_000;
        n_err++;
        $display("FAIL timeout: got still running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
